// File: rtl/U.sv
// Word type and wildcard classification patterns for the U opcode space.
// Patterns are zero-extended to 8 bits, so any word with a nonzero upper nibble is illegal.
package U;

  typedef logic [7:0] u_t;

  localparam u_t AAA = 8'b0000_0?00;
  localparam u_t BBB = 8'b0000_0?01;
  localparam u_t CCC = 8'b0000_1??1;
  localparam u_t DDD = 8'b0000_1??0;
  localparam u_t EEE = 8'b0000_0?1?;

endpackage

// File: rtl/uq_pkg.sv
// Shared class encoding and FIFO entry layout for the U classification queue.
package uq_pkg;

  typedef logic [3:0] cls_t;

  localparam cls_t CLS_ILLEGAL = 4'd0;
  localparam cls_t CLS_AAA     = 4'd1;
  localparam cls_t CLS_BBB     = 4'd2;
  localparam cls_t CLS_CCC     = 4'd3;
  localparam cls_t CLS_DDD     = 4'd4;
  localparam cls_t CLS_EEE     = 4'd5;
  localparam int   NCLS        = 6;

  typedef struct packed {
    U::u_t u;
    cls_t  cls;
  } entry_t;

endpackage

// File: rtl/u_class_dec.sv
// Combinational classifier: maps a U word onto its pattern class, or CLS_ILLEGAL.
module u_class_dec
  import uq_pkg::*;
(
  input  U::u_t u_i,
  output cls_t  cls_o,
  output logic  legal_o
);

  // The U patterns are mutually exclusive, so at most one arm can ever match.
  always_comb begin
    cls_o = CLS_ILLEGAL;
    unique casez (u_i)
      U::AAA:  cls_o = CLS_AAA;
      U::BBB:  cls_o = CLS_BBB;
      U::CCC:  cls_o = CLS_CCC;
      U::DDD:  cls_o = CLS_DDD;
      U::EEE:  cls_o = CLS_EEE;
      default: cls_o = CLS_ILLEGAL;
    endcase
  end

  assign legal_o = (cls_o != CLS_ILLEGAL);

endmodule

// File: rtl/u_class_queue.sv
// Classifies incoming U words, buffers {word, class} in a small FIFO and keeps
// per-class occurrence counters plus a one-cycle illegal-word pulse.
module u_class_queue
  import uq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  U::u_t                      in_u,
  output logic                       in_ready,
  output logic                       out_valid,
  output U::u_t                      out_u,
  output cls_t                       out_cls,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occ,
  output logic                       err_illegal,
  input  logic                       clr_cnt,
  output logic [NCLS-1:0][CW-1:0]    cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  entry_t                   mem_q [DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]            occ_q, occ_d;
  logic [NCLS-1:0][CW-1:0]  cnt_q, cnt_d;
  logic                     err_q, err_d;
  cls_t                     dec_cls;
  logic                     dec_legal;
  logic                     accept, pop;

  u_class_dec u_dec (
    .u_i     (in_u),
    .cls_o   (dec_cls),
    .legal_o (dec_legal)
  );

  // Ready/valid come from occupancy alone, so there is no path from out_ready to in_ready.
  assign in_ready  = (occ_q != FULL);
  assign out_valid = (occ_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    err_d    = accept && !dec_legal;
    if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
    if (accept && !pop)      occ_d = occ_q + OW'(1);
    else if (!accept && pop) occ_d = occ_q - OW'(1);
    else                     occ_d = occ_q;
    // A clear wins over a same-cycle increment.
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (accept) begin
      for (int c = 0; c < NCLS; c++) begin
        if (dec_cls == cls_t'(c)) cnt_d[c] = cnt_q[c] + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (accept) mem_q[wr_ptr_q] <= '{u: in_u, cls: dec_cls};
    end
  end

  assign out_u       = mem_q[rd_ptr_q].u;
  assign out_cls     = mem_q[rd_ptr_q].cls;
  assign occ         = occ_q;
  assign cnt         = cnt_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_u_class_queue.sv
// Randomized and directed bench for u_class_queue with a queue-based scoreboard.
module tb_u_class_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_u;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_u;
  logic [3:0]       out_cls;
  logic             out_ready;
  logic [2:0]       occ;
  logic             err_illegal;
  logic             clr_cnt;
  logic [5:0][7:0]  cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] exp_q [$];
  int          exp_cnt [6];
  logic        exp_err = 1'b0;

  u_class_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_u        (in_u),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_u       (out_u),
    .out_cls     (out_cls),
    .out_ready   (out_ready),
    .occ         (occ),
    .err_illegal (err_illegal),
    .clr_cnt     (clr_cnt),
    .cnt         (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference classification from the pattern table, using plain arithmetic.
  function automatic int cls_of(input int u);
    if (u > 15) return 0;
    if ((u / 8) % 2 == 1) return (u % 2 == 1) ? 3 : 4;
    if ((u / 2) % 2 == 1) return 5;
    return (u % 2 == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compare state against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    logic [11:0] hd;
    int          cl;
    bit          acc;
    bit          pp;
    chk("occ", 32'(occ), 32'(exp_q.size()));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("err_illegal", 32'(err_illegal), 32'(exp_err));
    for (int c = 0; c < 6; c++) chk("cnt", 32'(cnt[c]), 32'(exp_cnt[c]));
    acc = in_valid && (exp_q.size() != DEPTH);
    pp  = out_ready && (exp_q.size() != 0);
    if (pp) begin
      hd = exp_q.pop_front();
      chk("out_u", 32'(out_u), 32'(hd[11:4]));
      chk("out_cls", 32'(out_cls), 32'(hd[3:0]));
    end
    cl = cls_of(int'(in_u));
    if (acc) exp_q.push_back({in_u, 4'(cl)});
    exp_err = acc && (cl == 0);
    if (clr_cnt) begin
      for (int c = 0; c < 6; c++) exp_cnt[c] = 0;
    end else if (acc) begin
      exp_cnt[cl] = (exp_cnt[cl] + 1) % 256;
    end
    if (reset) begin
      exp_q.delete();
      for (int c = 0; c < 6; c++) exp_cnt[c] = 0;
      exp_err = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] u);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_u     = u;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0 for word %0h", u);
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dir_words [7];
    dir_words = '{8'h00, 8'h05, 8'h09, 8'h0C, 8'h02, 8'h10, 8'h0F};
    for (int c = 0; c < 6; c++) exp_cnt[c] = 0;
    reset = 1'b1; in_valid = 1'b0; in_u = 8'h00; out_ready = 1'b0; clr_cnt = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_out_u", 32'(out_u), 32'h0);
    chk("reset_out_cls", 32'(out_cls), 32'h0);

    // Directed classes 1..5, then illegal and class 3.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(dir_words[i]);
    repeat (3) tick();

    // Fill with the consumer stalled, then release while the 5th word waits.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h08 + i));
    fork
      push(8'h0E);
      begin repeat (3) tick(); out_ready = 1'b1; end
    join
    repeat (6) tick();

    // Steady accept+pop at occupancy 2.
    out_ready = 1'b0;
    push(8'h04);
    push(8'h0B);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(8'($urandom_range(0, 15)));
    repeat (4) tick();

    // Clear colliding with an accept, then wrap cnt[2].
    in_valid = 1'b1; in_u = 8'h00; clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0; in_u = 8'h01;
    repeat (256) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("cnt2_wrap", 32'(cnt[2]), 32'h0);

    // Reset with three queued words, overriding a same-cycle accept and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'h01 + i));
    reset = 1'b1; in_valid = 1'b1; in_u = 8'h05; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    push(8'h09);
    tick();
    out_ready = 1'b1;
    repeat (2) tick();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_u      = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      clr_cnt   = ($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
